// File: rtl/fifo_mem_pkg.sv
// Shared constants and helpers for the parametrised FIFO memory.
package fifo_mem_pkg;

    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefAddrW    = 4;
    localparam int unsigned DefAemptyTh = 2;

    // Fill level spans 0..DEPTH inclusive, so it needs one bit more than the address.
    function automatic int unsigned count_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_W x 2**ADDR_W storage: one synchronous write port, one read port.
// Read port is registered by default; with FIFO_MEM_PARAM_FWFT_EN defined it
// becomes an asynchronous read so the head word falls through.
module fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef FIFO_MEM_PARAM_FWFT_EN
    logic unused_rd;
    assign unused_rd = ^{rst_n, re_i};
    assign rdata_o   = mem_q[raddr_i];
`else
    logic [DATA_W-1:0] rdata_q;

    // Registered read; a same-slot write in this cycle leaves the old word here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/fifo_mem_param.sv
// Parametrised synchronous FIFO with fill level, almost flags, flush and
// sticky overflow/underflow. Define FIFO_MEM_PARAM_FWFT_EN for first-word-fall-through.
module fifo_mem_param
    import fifo_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned AFULL_TH  = (2 ** ADDR_W) - 2,
    parameter int unsigned AEMPTY_TH = DefAemptyTh
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       fifo_almost_full,
    output logic                       fifo_almost_empty,
    output logic [count_w(ADDR_W)-1:0] fifo_count,
    output logic                       fifo_overflow,
    output logic                       fifo_underflow
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = count_w(ADDR_W);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            we, re;

    // Status decode from registered pointers; count is modulo 2**(ADDR_W+1).
    always_comb begin
        fifo_count        = wptr_q - rptr_q;
        fifo_full         = (fifo_count == CntW'(Depth));
        fifo_empty        = (fifo_count == '0);
        fifo_almost_full  = (fifo_count >= CntW'(AFULL_TH));
        fifo_almost_empty = (fifo_count <= CntW'(AEMPTY_TH));
    end

    // Acceptance and next-state; clr overrides any access in the same cycle.
    always_comb begin
        we     = wr & ~clr & (~fifo_full | rd);
        re     = rd & ~clr & ~fifo_empty;
        wptr_d = wptr_q + {{ADDR_W{1'b0}}, we};
        rptr_d = rptr_q + {{ADDR_W{1'b0}}, re};
        ovf_d  = ovf_q | (wr & ~we);
        udf_d  = udf_q | (rd & ~re);
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end
    end

    // Pointer and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (data_in),
        .re_i    (re),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_fifo_mem_param.sv
// Self-checking bench for fifo_mem_param: queue model plus literal pins.
module tb_fifo_mem_param;

    localparam int Depth = 16;
    localparam int AfTh  = 14;
    localparam int AeTh  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [4:0] fifo_count;
    logic       fifo_overflow, fifo_underflow;

    fifo_mem_param dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clr               (clr),
        .wr                (wr),
        .rd                (rd),
        .data_in           (data_in),
        .data_out          (data_out),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         chk_en = 1'b1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("count", 32'(fifo_count), 32'(q.size()));
                check("full", 32'(fifo_full), 32'(q.size() == Depth));
                check("empty", 32'(fifo_empty), 32'(q.size() == 0));
                check("afull", 32'(fifo_almost_full), 32'(q.size() >= AfTh));
                check("aempty", 32'(fifo_almost_empty), 32'(q.size() <= AeTh));
                check("ovf", 32'(fifo_overflow), 32'(m_ovf));
                check("udf", 32'(fifo_underflow), 32'(m_udf));
`ifdef FIFO_MEM_PARAM_FWFT_EN
                if (q.size() > 0) check("dout_fwft", 32'(data_out), 32'(q[0]));
`else
                check("dout", 32'(data_out), 32'(m_dout));
`endif
            end
        end
    end

    // One clock of stimulus; the model advances at the same edge as the DUT.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
        int sz;
        bit aw, ar;
        wr = w; rd = r; clr = c; data_in = d;
        @(posedge clk);
        sz = q.size();
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            ar = r && (sz > 0);
            aw = w && ((sz < Depth) || r);
            if (ar) m_dout = q.pop_front();
            if (aw) q.push_back(d);
            if (w && !aw) m_ovf = 1'b1;
            if (r && !ar) m_udf = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_aempty", 32'(fifo_almost_empty), 32'd1);
        check("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 0, 0, 8'h00);

        // Fill 0x00..0x0F
        for (int i = 0; i < Depth; i++) begin
            cycle(1, 0, 0, 8'(i));
            check("fill_count", 32'(fifo_count), 32'(i + 1));
            check("fill_afull", 32'(fifo_almost_full), 32'((i + 1) >= 14));
        end
        check("fill_full", 32'(fifo_full), 32'd1);

        // Full + simultaneous read/write returns oldest word
        cycle(1, 1, 0, 8'hA5);
        check("simul_count", 32'(fifo_count), 32'd16);
        check("simul_ovf", 32'(fifo_overflow), 32'd0);
`ifndef FIFO_MEM_PARAM_FWFT_EN
        check("simul_dout", 32'(data_out), 32'h00);
`endif
        for (int i = 0; i < Depth; i++) begin
            cycle(0, 1, 0, 8'h00);
`ifndef FIFO_MEM_PARAM_FWFT_EN
            check("drain_dout", 32'(data_out), (i == Depth - 1) ? 32'hA5 : 32'(i + 1));
`endif
        end
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // Overflow and underflow stickiness, then flush
        for (int i = 0; i < Depth; i++) cycle(1, 0, 0, 8'(8'h40 + i));
        cycle(1, 0, 0, 8'hEE);
        check("ovf_set", 32'(fifo_overflow), 32'd1);
        for (int i = 0; i < Depth; i++) cycle(0, 1, 0, 8'h00);
        check("ovf_sticky", 32'(fifo_overflow), 32'd1);
        cycle(1, 1, 0, 8'h5A);
        check("udf_set", 32'(fifo_underflow), 32'd1);
        check("udf_wr_count", 32'(fifo_count), 32'd1);
        cycle(1, 1, 1, 8'h11);
        check("clr_ovf", 32'(fifo_overflow), 32'd0);
        check("clr_udf", 32'(fifo_underflow), 32'd0);
        check("clr_count", 32'(fifo_count), 32'd0);

        // Random traffic with phases biased toward full and toward empty
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = ((i / 50) % 2 == 1) ? 30 : 75;
            cycle(($urandom_range(99) < pw), ($urandom_range(99) < (100 - pw)),
                  ($urandom_range(199) == 0), 8'($urandom));
        end

        // Asynchronous reset mid-burst at count 9
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 8'(8'h90 + i));
        check("pre_rst_count", 32'(fifo_count), 32'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_empty", 32'(fifo_empty), 32'd1);
        check("arst_full", 32'(fifo_full), 32'd0);
        check("arst_afull", 32'(fifo_almost_full), 32'd0);
        check("arst_aempty", 32'(fifo_almost_empty), 32'd1);
        check("arst_dout", 32'(data_out), 32'd0);
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 0, 8'h77);
`ifdef FIFO_MEM_PARAM_FWFT_EN
        check("post_rst_fwft", 32'(data_out), 32'h77);
`endif
        cycle(0, 1, 0, 8'h00);
`ifndef FIFO_MEM_PARAM_FWFT_EN
        check("post_rst_dout", 32'(data_out), 32'h77);
`endif

`ifdef FIFO_MEM_PARAM_FWFT_EN
        // Fall-through: word visible with no rd, popped by rd
        cycle(0, 0, 1, 8'h00);
        cycle(1, 0, 0, 8'h3C);
        check("fwft_dout", 32'(data_out), 32'h3C);
        check("fwft_nempty", 32'(fifo_empty), 32'd0);
        cycle(0, 1, 0, 8'h00);
        check("fwft_empty", 32'(fifo_empty), 32'd1);
`endif

        cycle(0, 0, 0, 8'h00);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
